// File: rtl/bit_serializer_if.sv
// Purpose : bundles the word-in / bit-out stream signals of bit_serializer.
// Latency : none, wires only.
// Backpressure: vld/busy on both sides; a transfer happens on an edge with vld=1 and busy=0.
//
// Signals:
//   din_vld   producer presents a word        din_busy   serializer cannot take it
//   din_data  WIDTH-bit word
//   dout_vld  a serial bit is presented       dout_busy  consumer cannot take it
//   dout_data current serial bit              dout_last  bit is the final one of its word
// master = producer/consumer side, slave = serializer side.
interface bit_serializer_if #(
    parameter int WIDTH = 16
);
    logic             din_vld;
    logic             din_busy;
    logic [WIDTH-1:0] din_data;
    logic             dout_vld;
    logic             dout_busy;
    logic             dout_data;
    logic             dout_last;

    modport master (
        output din_vld, din_data, dout_busy,
        input  din_busy, dout_vld, dout_data, dout_last
    );

    modport slave (
        input  din_vld, din_data, dout_busy,
        output din_busy, dout_vld, dout_data, dout_last
    );
endinterface

// File: rtl/bit_serializer.sv
// Purpose : 16-bit (WIDTH) word to 1-bit stream serializer with a one-word holding buffer.
// Latency : word accepted at edge N, first bit valid after edge N+1; one bit per cycle, no gap between words.
// Backpressure: din_busy = buffer full (registered); dout_busy freezes shifter and output bit.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset; discards buffered and partial words
//   bus  slave side of bit_serializer_if (din_* word input, dout_* bit output)
module bit_serializer #(
    parameter int WIDTH     = 16,
    parameter int MSB_FIRST = 1,
    parameter int CW        = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    bit_serializer_if.slave  bus
);

    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q,     state_d;
    logic [WIDTH-1:0] hold_data_q, hold_data_d;
    logic             hold_full_q, hold_full_d;
    logic [WIDTH-1:0] sr_q,        sr_d;
    logic [CW-1:0]    cnt_q,       cnt_d;

    logic in_xfer;
    logic out_xfer;
    logic last_xfer;

    // Buffer and shifter loads are mutually exclusive: both are gated by hold_full_q,
    // one needing it low and the other high, so the buffer never loads and drains on one edge.
    assign in_xfer   = bus.din_vld && !hold_full_q;
    assign out_xfer  = (state_q == SHIFT) && !bus.dout_busy;
    assign last_xfer = out_xfer && (cnt_q == LAST_CNT);

    always_comb begin
        state_d     = state_q;
        hold_data_d = hold_data_q;
        hold_full_d = hold_full_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;

        if (in_xfer) begin
            hold_data_d = bus.din_data;
            hold_full_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    sr_d        = hold_data_q;
                    cnt_d       = '0;
                    hold_full_d = 1'b0;
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                if (last_xfer && hold_full_q) begin
                    // Reload straight from the buffer so the next word follows without a bubble.
                    sr_d        = hold_data_q;
                    cnt_d       = '0;
                    hold_full_d = 1'b0;
                end else if (out_xfer) begin
                    if (MSB_FIRST != 0) begin
                        sr_d = {sr_q[WIDTH-2:0], 1'b0};
                    end else begin
                        sr_d = {1'b0, sr_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (last_xfer) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            hold_data_q <= '0;
            hold_full_q <= 1'b0;
            sr_q        <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            hold_data_q <= hold_data_d;
            hold_full_q <= hold_full_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
        end
    end

    // All outputs decode registers only; no input reaches an output combinationally.
    assign bus.din_busy  = hold_full_q;
    assign bus.dout_vld  = (state_q == SHIFT);
    assign bus.dout_data = (MSB_FIRST != 0) ? sr_q[WIDTH-1] : sr_q[0];
    assign bus.dout_last = (cnt_q == LAST_CNT) && (state_q == SHIFT);

endmodule

// File: tb/tb_bit_serializer.sv
module tb_bit_serializer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    bit_serializer_if #(.WIDTH(16)) bus ();

    bit_serializer #(
        .WIDTH     (16),
        .MSB_FIRST (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        rst;
        logic        vld;
        logic [15:0] data;
        logic        busy;
        logic        edb;
        logic        ev;
        logic        ed;
        logic        el;
        logic        chk_d;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic r, input logic v, input logic [15:0] d, input logic b,
                                input logic edb, input logic ev, input logic ed, input logic el,
                                input logic chk_d);
        vec_t t;
        t.rst = r; t.vld = v; t.data = d; t.busy = b;
        t.edb = edb; t.ev = ev; t.ed = ed; t.el = el; t.chk_d = chk_d;
        tbl.push_back(t);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Check the 16 bits of word w on consecutive cycles, MSB first, dout_busy=0.
    task automatic check_word(input string name, input logic [15:0] w);
        for (int i = 0; i < 16; i++) begin
            chk({name, " vld"},  32'(bus.dout_vld),  32'd1);
            chk({name, " bit"},  32'(bus.dout_data), 32'(w[15-i]));
            chk({name, " last"}, 32'(bus.dout_last), 32'(i == 15));
            cyc();
        end
        chk({name, " end vld"}, 32'(bus.dout_vld), 32'd0);
    endtask

    initial begin
        logic [15:0] w;

        bus.din_vld   = 1'b1;
        bus.din_data  = 16'hA5C3;
        bus.dout_busy = 1'b0;

        // ---------------- table: reset, single word, back-to-back ----------------
        // Each entry: check outputs now, then apply inputs, then advance one edge.
        for (int i = 0; i < 3; i++) add(1'b0, 1'b1, 16'hA5C3, 1'b0, 0, 0, 0, 0, 1);
        add(1'b1, 1'b1, 16'hA5C3, 1'b0, 0, 0, 0, 0, 1);  // release rst between edges
        add(1'b1, 1'b0, 16'h0000, 1'b0, 1, 0, 0, 0, 0);  // accepted at first edge after release
        w = 16'hA5C3;
        for (int i = 0; i < 16; i++) add(1'b1, 1'b0, 16'h0000, 1'b0, 0, 1, w[15-i], i == 15, 1);
        add(1'b1, 1'b1, 16'hFFFF, 1'b0, 0, 0, 0, 0, 0);  // idle; offer 0xFFFF
        add(1'b1, 1'b1, 16'h0001, 1'b0, 1, 0, 0, 0, 0);  // buffered; 0x0001 waits
        add(1'b1, 1'b1, 16'h0001, 1'b0, 0, 1, 1, 0, 1);  // bit 1 of 0xFFFF; buffer reopens
        for (int i = 1; i < 16; i++) add(1'b1, 1'b0, 16'h0000, 1'b0, 1, 1, 1, i == 15, 1);
        w = 16'h0001;
        for (int i = 0; i < 16; i++) add(1'b1, 1'b0, 16'h0000, 1'b0, 0, 1, w[15-i], i == 15, 1);
        add(1'b1, 1'b0, 16'h0000, 1'b0, 0, 0, 0, 0, 0);

        #1 rst = 1'b0;  // guaranteed negedge for the async reset
        #1;
        foreach (tbl[k]) begin
            chk($sformatf("v%0d din_busy", k),  32'(bus.din_busy),  32'(tbl[k].edb));
            chk($sformatf("v%0d dout_vld", k),  32'(bus.dout_vld),  32'(tbl[k].ev));
            chk($sformatf("v%0d dout_last", k), 32'(bus.dout_last), 32'(tbl[k].el));
            if (tbl[k].chk_d)
                chk($sformatf("v%0d dout_data", k), 32'(bus.dout_data), 32'(tbl[k].ed));
            rst           = tbl[k].rst;
            bus.din_vld   = tbl[k].vld;
            bus.din_data  = tbl[k].data;
            bus.dout_busy = tbl[k].busy;
            cyc();
        end

        // ---------------- backpressure on transfer index 7 of 0x00F0 ----------------
        w = 16'h00F0;
        bus.din_vld = 1'b1; bus.din_data = w;
        cyc();
        bus.din_vld = 1'b0;
        cyc();
        for (int i = 0; i < 7; i++) begin
            chk("bp pre bit", 32'(bus.dout_data), 32'(w[15-i]));
            cyc();
        end
        bus.dout_busy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("bp hold vld",  32'(bus.dout_vld),  32'd1);
            chk("bp hold bit",  32'(bus.dout_data), 32'd0);
            chk("bp hold cnt",  32'(dut.cnt_q),     32'd7);
            chk("bp hold last", 32'(bus.dout_last), 32'd0);
            if (i < 5) cyc();
        end
        bus.dout_busy = 1'b0;
        for (int i = 7; i < 16; i++) begin
            chk("bp post bit",  32'(bus.dout_data), 32'(w[15-i]));
            chk("bp post last", 32'(bus.dout_last), 32'(i == 15));
            cyc();
        end
        chk("bp end vld", 32'(bus.dout_vld), 32'd0);

        // ---------------- buffer full: changing din_data ignored ----------------
        w = 16'hAAAA;
        bus.din_vld = 1'b1; bus.din_data = w;
        cyc();                                   // 0xAAAA into buffer
        bus.din_data = 16'h1234;
        cyc();                                   // shifter loads 0xAAAA
        chk("bf bit0", 32'(bus.dout_data), 32'd1);
        cyc();                                   // 0x1234 into buffer
        for (int i = 1; i < 16; i++) begin
            chk("bf din_busy", 32'(bus.din_busy),  32'd1);
            chk("bf aaaa bit", 32'(bus.dout_data), 32'(w[15-i]));
            bus.din_data = 16'($urandom);
            cyc();
        end
        bus.din_vld = 1'b0;
        chk("bf reopen", 32'(bus.din_busy), 32'd0);
        check_word("bf 1234", 16'h1234);

        // ---------------- reset mid-word ----------------
        w = 16'hBEEF;
        bus.din_vld = 1'b1; bus.din_data = w;
        cyc();
        bus.din_data = 16'h1111;
        cyc();                                   // shifter loads 0xBEEF
        cyc();                                   // 0x1111 buffered, cnt=1
        bus.din_vld = 1'b0;
        repeat (4) cyc();
        chk("rm bit5",  32'(bus.dout_data), 32'(w[10]));
        chk("rm full",  32'(bus.din_busy),  32'd1);
        #2 rst = 1'b0;
        #1;
        chk("rm vld",   32'(bus.dout_vld),  32'd0);
        chk("rm busy",  32'(bus.din_busy),  32'd0);
        chk("rm last",  32'(bus.dout_last), 32'd0);
        chk("rm data",  32'(bus.dout_data), 32'd0);
        cyc();
        rst = 1'b1;
        bus.din_vld = 1'b1; bus.din_data = 16'h8001;
        cyc();
        chk("rm accept", 32'(bus.din_busy), 32'd1);
        chk("rm no vld", 32'(bus.dout_vld), 32'd0);
        bus.din_vld = 1'b0;
        cyc();
        check_word("rm 8001", 16'h8001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Word-to-bit serializer for the flow-controlled streaming interface used by `dut`. It accepts 16-bit words on a vld/busy input port and emits them one bit per transfer on a vld/busy output port. It is the transmit end of that path: it generates the 1-bit `din_data` stream that `dut` consumes. A one-word holding buffer in front of the shifter sustains one bit per cycle across back-to-back words.

## Interface
- WIDTH, 16: word width in bits; must be ≥ 2.
- MSB_FIRST, 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.
- CW, $clog2(WIDTH): width of the bit counter.

Ports (name, direction, width, meaning):
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-low.
- din_vld  in  1  producer presents a word.
- din_busy  out  1  serializer cannot accept a word this cycle.
- din_data  in  WIDTH  word to serialize.
- dout_vld  out  1  a bit is presented.
- dout_busy  in  1  consumer cannot take the bit.
- dout_data  out  1  current serial bit.
- dout_last  out  1  the current bit is the final bit of its word.

## Operation
- Handshake on both ports: a transfer happens at a rising clk edge where vld=1 and busy=0. Otherwise nothing transfers.
- Holding buffer (`hold_data`, `hold_full`):
  - `din_busy` = `hold_full`, driven straight from the register.
  - An input transfer loads `din_data` into `hold_data` and sets `hold_full`.
  - While `hold_full`=1, `din_data` is ignored.
- Shifter (`sr`, `cnt`), two states:
  - IDLE: `dout_vld`=0.
  - SHIFT: `dout_vld`=1.
- IDLE → SHIFT on a clk edge with `hold_full`=1. At that edge: `sr`←`hold_data`, `cnt`←0, `hold_full`←0.
- In SHIFT, on each output transfer:
  - MSB_FIRST=1: `sr` shifts left. MSB_FIRST=0: `sr` shifts right.
  - `cnt` increments.
- When the transfer has `cnt`=WIDTH-1:
  - If `hold_full`=1: reload `sr`, `cnt`, `hold_full` as in IDLE → SHIFT and stay in SHIFT, so there is no bubble.
  - Otherwise go to IDLE.
- Output bit:
  - `dout_data` = `sr[WIDTH-1]` when MSB_FIRST=1, else `sr[0]`.
  - `dout_last` = (`cnt`==WIDTH-1) && `dout_vld`.
- While `dout_busy`=1, `sr`, `cnt`, `dout_data` and `dout_last` hold.
- Simultaneous events:
  - At an edge where the last bit transfers and the shifter reloads, `din_busy` was 1, so no input is accepted. `hold_full` clears and input reopens next cycle.
  - At an edge where IDLE loads the shifter from the buffer, the buffer was full, so no new word enters that edge.
- Reset (rst=0) clears immediately, without waiting for clk:
  - `hold_full`, state (→ IDLE), `cnt`, `sr` and `hold_data`.
  - Partial and buffered words are discarded.
  - Reset values: `din_busy`=0, `dout_vld`=0, `dout_data`=0, `dout_last`=0.
- After rst rises, the first input edge may accept a word.

## Timing
- Latency: a word accepted at edge N → `hold_full`=1 after N → shifter loads at edge N+1 → first bit valid (`dout_vld`=1) after N+1.
- Throughput with `dout_busy`=0 and `din_vld`=1 continuously: one bit per cycle with no gap between words.
- Input acceptance under that load: one word every WIDTH cycles. `din_busy` is high for WIDTH-1 of every WIDTH cycles in steady state.
- The output keeps its bit stable from the edge it appears until the edge it transfers.
- All outputs are registered or decoded from registers only. There are no combinational paths from any input to any output.

## Test plan
- Reset: hold rst=0 for 3 cycles, driving `din_vld`=1 and `dout_busy`=0.
  - Required: `din_busy`, `dout_vld`, `dout_data`, `dout_last` all 0.
  - First word accepted at the first edge after rst rises.
- Single word 0xA5C3, MSB_FIRST=1, `dout_busy`=0, accepted at edge N.
  - First bit valid after N+1.
  - Bits 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1 on 16 consecutive cycles.
  - `dout_last`=1 only on the 16th bit, then `dout_vld`=0.
- Back-to-back 0xFFFF then 0x0001, `din_vld` held high:
  - 32 consecutive valid bits, no bubble.
  - `dout_last` on bits 16 and 32.
  - Second word accepted the cycle after the first one leaves the buffer.
- Backpressure: `dout_busy`=1 for 5 cycles while bit 7 of 0x00F0 is presented.
  - `dout_data`=0 and `cnt` are stable throughout.
  - After release the remaining bits follow unchanged; no bit is lost or duplicated.
- Buffer full: `din_vld`=1 with `din_data` changing every cycle while a word shifts and the buffer holds 0x1234.
  - `din_busy`=1; the changing data is ignored.
  - The next word emitted is exactly 0x1234.
- Reset mid-word: rst=0 between edges while bit 5 of 0xBEEF is presented, with a word buffered.
  - `dout_vld` and `din_busy` drop to 0 before the next edge.
  - After release, word 0x8001 serializes from its first bit; nothing of 0xBEEF reappears.
